// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase controller.
package pll_phase_pkg;

  localparam int PLL_NUM_OUTPUTS = 4;

  typedef enum logic [1:0] {
    SEL_CLKOP  = 2'd0,
    SEL_CLKOS  = 2'd1,
    SEL_CLKOS2 = 2'd2,
    SEL_CLKOS3 = 2'd3
  } pll_out_sel_e;

  typedef logic [7:0] phase_pos_t;

  // IDLE wait req | SETUP sel/dir settle | STEP_HI/STEP_GAP pulse | LOAD loadreg | LOCK_WAIT relock | DONE pulse
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_STEP_HI   = 3'd2,
    ST_STEP_GAP  = 3'd3,
    ST_LOAD      = 3'd4,
    ST_LOCK_WAIT = 3'd5,
    ST_DONE      = 3'd6
  } pll_state_e;

  function automatic phase_pos_t phase_step(input phase_pos_t pos, input logic dir);
    return dir ? phase_pos_t'(pos - 8'd1) : phase_pos_t'(pos + 8'd1);
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_ecp5_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK into clk_sys.
module pll_lock_sync (
  input  logic clk_sys,
  input  logic rst_sys,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_phase_ctrl_ecp5.sv
// Sequencer for the EHXPLLL dynamic phase-adjust port: stepping, relock wait, done/err reporting.
// Define PLL_PHASE_CTRL_LOAD_EN to insert a PHASELOADREG pulse between the last step and lock wait.
module pll_phase_ctrl_ecp5
  import pll_phase_pkg::*;
#(
  parameter int STEP_HI_CYCLES     = 4,
  parameter int STEP_GAP_CYCLES    = 8,
  parameter int SETUP_CYCLES       = 2,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT       = 65535
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_sel_i,
  input  logic        req_dir_i,
  input  logic [7:0]  req_steps_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] phase_pos_o,
  input  logic        pll_lock_i,
  output logic [1:0]  pll_phasesel_o,
  output logic        pll_phasedir_o,
  output logic        pll_phasestep_o,
  output logic        pll_phaseloadreg_o
);

  localparam logic [15:0] SETUP_LD    = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] HI_LD       = 16'(STEP_HI_CYCLES - 1);
  localparam logic [15:0] GAP_LD      = 16'(STEP_GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LD      = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);

  pll_state_e   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  stable_q, stable_d;
  logic [7:0]   steps_q, steps_d;
  pll_out_sel_e sel_q, sel_d;
  logic         dir_q, dir_d;
  logic         err_q, err_d;
  phase_pos_t   pos_q [PLL_NUM_OUTPUTS];
  phase_pos_t   pos_d [PLL_NUM_OUTPUTS];
  logic         ready_q, done_q, step_q;
  logic         lock_s;
  logic         cnt_zero;

  pll_lock_sync u_lock_sync (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .async_i (pll_lock_i),
    .sync_o  (lock_s)
  );

  assign cnt_zero = (cnt_q == 16'd0);

  // One shared down-counter; each state reloads it on exit for the next phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - 16'd1;
    stable_d = stable_q;
    steps_d  = steps_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    err_d    = err_q;
    pos_d    = pos_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          sel_d   = pll_out_sel_e'(req_sel_i);
          dir_d   = req_dir_i;
          steps_d = req_steps_i;
          err_d   = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          if (steps_q != 8'd0) begin
            cnt_d   = HI_LD;
            state_d = ST_STEP_HI;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_STEP_HI: begin
        if (cnt_zero) begin
          steps_d        = steps_q - 8'd1;
          pos_d[sel_q]   = phase_step(pos_q[sel_q], dir_q);
          cnt_d          = GAP_LD;
          state_d        = ST_STEP_GAP;
        end
      end
      ST_STEP_GAP: begin
        if (cnt_zero) begin
          if (steps_q != 8'd0) begin
            cnt_d   = HI_LD;
            state_d = ST_STEP_HI;
          end else begin
`ifdef PLL_PHASE_CTRL_LOAD_EN
            cnt_d   = HI_LD;
            state_d = ST_LOAD;
`else
            cnt_d    = TMO_LD;
            stable_d = 16'd0;
            state_d  = ST_LOCK_WAIT;
`endif
          end
        end
      end
      ST_LOAD: begin
        if (cnt_zero) begin
          cnt_d    = TMO_LD;
          stable_d = 16'd0;
          state_d  = ST_LOCK_WAIT;
        end
      end
      ST_LOCK_WAIT: begin
        // A stable lock reached on the last timeout cycle still counts as success.
        stable_d = lock_s ? stable_q + 16'd1 : 16'd0;
        if (lock_s && (stable_q == STABLE_LAST)) begin
          state_d = ST_DONE;
        end else if (cnt_zero) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      stable_q <= 16'd0;
      steps_q  <= 8'd0;
      sel_q    <= SEL_CLKOP;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      pos_q    <= '{default: '0};
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      steps_q  <= steps_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      pos_q    <= pos_d;
      ready_q  <= (state_d == ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      step_q   <= (state_d == ST_STEP_HI);
    end
  end

`ifdef PLL_PHASE_CTRL_LOAD_EN
  logic load_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      load_q <= 1'b0;
    end else begin
      load_q <= (state_d == ST_LOAD);
    end
  end

  assign pll_phaseloadreg_o = load_q;
`else
  assign pll_phaseloadreg_o = 1'b0;
`endif

  for (genvar k = 0; k < PLL_NUM_OUTPUTS; k++) begin : g_pos
    assign phase_pos_o[8*k +: 8] = pos_q[k];
  end

  assign req_ready_o     = ready_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign pll_phasesel_o  = sel_q;
  assign pll_phasedir_o  = dir_q;
  assign pll_phasestep_o = step_q;

endmodule

// File: tb/tb_pll_phase_ctrl_ecp5.sv
// Scoreboard bench for pll_phase_ctrl_ecp5: randomized requests against a cycle-level reference model.
module tb_pll_phase_ctrl_ecp5;

  localparam int SETUP  = 2;
  localparam int HI     = 4;
  localparam int GAP    = 8;
  localparam int STABLE = 16;
  localparam int TMO    = 400;
`ifdef PLL_PHASE_CTRL_LOAD_EN
  localparam int LOADX  = HI;
`else
  localparam int LOADX  = 0;
`endif

  typedef struct {
    int         done_cyc;
    bit         err;
    logic [31:0] pos;
    int         steps;
    logic [1:0] sel;
    bit         dir;
    int         load;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_sel_i = 2'd0;
  logic        req_dir_i = 1'b0;
  logic [7:0]  req_steps_i = 8'd0;
  logic        done_o;
  logic        err_o;
  logic [31:0] phase_pos_o;
  logic        pll_lock_i = 1'b1;
  logic [1:0]  pll_phasesel_o;
  logic        pll_phasedir_o;
  logic        pll_phasestep_o;
  logic        pll_phaseloadreg_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [7:0] mpos [4];

  int   hi_run = 0, lo_run = 0, pulses = 0, load_cnt = 0;
  bit   prev_done = 0;
  exp_t me;

  pll_phase_ctrl_ecp5 #(
    .STEP_HI_CYCLES     (HI),
    .STEP_GAP_CYCLES    (GAP),
    .SETUP_CYCLES       (SETUP),
    .LOCK_STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT       (TMO)
  ) dut (
    .clk_sys            (clk_sys),
    .rst_sys            (rst_sys),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_sel_i          (req_sel_i),
    .req_dir_i          (req_dir_i),
    .req_steps_i        (req_steps_i),
    .done_o             (done_o),
    .err_o              (err_o),
    .phase_pos_o        (phase_pos_o),
    .pll_lock_i         (pll_lock_i),
    .pll_phasesel_o     (pll_phasesel_o),
    .pll_phasedir_o     (pll_phasedir_o),
    .pll_phasestep_o    (pll_phasestep_o),
    .pll_phaseloadreg_o (pll_phaseloadreg_o)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_pos();
    return {mpos[3], mpos[2], mpos[1], mpos[0]};
  endfunction

  // Raw lock stimulus relative to the accept cycle: 0 steady high, 1 one-cycle drop at g, 2 low from g on.
  function automatic logic lock_fn(input int mode, input int g, input int rel);
    case (mode)
      1:       return rel != g;
      2:       return rel < g;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int lw_entry(input int steps);
    return 1 + SETUP + steps * (HI + GAP) + LOADX;
  endfunction

  // Cycles from accept to done, derived from the state-duration rules and a 2-cycle lock sync delay.
  function automatic int model_lat(input int steps, input int mode, input int g, output bit er);
    int e, run;
    er = 1'b0;
    if (steps == 0) return SETUP + 1;
    e = lw_entry(steps);
    run = 0;
    for (int j = 0; j < TMO; j++) begin
      run = lock_fn(mode, g, e + j - 2) ? run + 1 : 0;
      if (run == STABLE) return e + j + 1;
    end
    er = 1'b1;
    return e + TMO;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready_o, 1);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_pos"}, phase_pos_o, 0);
    chk({tag, "_sel"}, pll_phasesel_o, 0);
    chk({tag, "_dir"}, pll_phasedir_o, 0);
    chk({tag, "_step"}, pll_phasestep_o, 0);
    chk({tag, "_load"}, pll_phaseloadreg_o, 0);
  endtask

  task automatic do_req(input logic [1:0] sel, input bit dir, input int steps,
                        input int mode, input int g);
    exp_t e;
    int   lat, t, acc, rel;
    bit   er, seen;
    lat = model_lat(steps, mode, g, er);
    @(negedge clk_sys);
    req_valid_i = 1'b1;
    req_sel_i   = sel;
    req_dir_i   = dir;
    req_steps_i = 8'(steps);
    t = 0;
    while (!req_ready_o && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    chk("accept_ready", req_ready_o, 1);
    acc = cyc;
    for (int k = 0; k < steps; k++) mpos[sel] = dir ? mpos[sel] - 8'd1 : mpos[sel] + 8'd1;
    e.done_cyc = acc + lat;
    e.err      = er;
    e.pos      = pack_pos();
    e.steps    = steps;
    e.sel      = sel;
    e.dir      = dir;
    e.load     = (steps != 0) ? LOADX : 0;
    sb.push_back(e);
    seen = 1'b0;
    t = 0;
    while (!seen && t < lat + 20) begin
      @(negedge clk_sys);
      t++;
      rel = cyc - acc;
      pll_lock_i = lock_fn(mode, g, rel);
      if (rel == 1) begin
        chk("err_cleared_on_accept", err_o, 0);
        chk("busy_not_ready", req_ready_o, 0);
      end
      if (done_o) begin
        seen = 1'b1;
        req_valid_i = 1'b0;
      end else begin
        req_valid_i = 1'($urandom_range(0, 1));
        req_sel_i   = 2'($urandom);
        req_dir_i   = 1'($urandom);
        req_steps_i = 8'($urandom);
      end
    end
    chk("done_seen", seen, 1);
    req_valid_i = 1'b0;
    pll_lock_i  = 1'b1;
  endtask

  task automatic reset_mid_step();
    int t;
    @(negedge clk_sys);
    req_valid_i = 1'b1;
    req_sel_i   = 2'd3;
    req_dir_i   = 1'b0;
    req_steps_i = 8'd5;
    t = 0;
    while (!req_ready_o && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    @(negedge clk_sys);
    req_valid_i = 1'b0;
    t = 0;
    while (!pll_phasestep_o && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    chk("rst_reached_step_hi", pll_phasestep_o, 1);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) mpos[i] = 8'd0;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
    repeat (6) @(negedge clk_sys);
    chk("post_rst_idle_ready", req_ready_o, 1);
  endtask

  // Monitor: pulse shape checks every cycle, scoreboard pop on each done pulse.
  always @(negedge clk_sys) begin
    if (rst_sys) begin
      hi_run = 0; lo_run = 0; pulses = 0; load_cnt = 0; prev_done = 0;
    end else begin
      if (prev_done) chk("ready_after_done", req_ready_o, 1);
      prev_done = done_o;
      if (pll_phasestep_o) begin
        if (hi_run == 0) begin
          if (pulses > 0) chk("step_gap_width", lo_run, GAP);
          if (sb.size() > 0) begin
            chk("phasesel_at_step", pll_phasesel_o, sb[0].sel);
            chk("phasedir_at_step", pll_phasedir_o, sb[0].dir);
          end
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run > 0) begin
          chk("step_hi_width", hi_run, HI);
          pulses++;
          hi_run = 0;
        end
        lo_run++;
      end
      if (pll_phaseloadreg_o) load_cnt++;
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          chk("done_cycle", cyc, me.done_cyc);
          chk("err_at_done", err_o, me.err);
          chk("phase_pos", phase_pos_o, me.pos);
          chk("pulse_count", pulses, me.steps);
          chk("load_cycles", load_cnt, me.load);
          chk("sel_held", pll_phasesel_o, me.sel);
          chk("dir_held", pll_phasedir_o, me.dir);
          chk("ready_low_in_done", req_ready_o, 0);
        end
        pulses = 0;
        load_cnt = 0;
      end
    end
  end

  initial begin
    int steps, mode, g;
    for (int i = 0; i < 4; i++) mpos[i] = 8'd0;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("in_rst");
    rst_sys = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("after_rst");

    do_req(2'd2, 1'b1, 1, 0, 0);
    do_req(2'd1, 1'b0, 3, 0, 0);
    do_req(2'd0, 1'b0, 1, 1, lw_entry(1) + 7);
    do_req(2'd3, 1'b1, 2, 2, lw_entry(2) - 3);
    repeat (3) @(negedge clk_sys);
    chk("err_sticky_idle", err_o, 1);
    do_req(2'd1, 1'b1, 0, 0, 0);

    for (int n = 0; n < 14; n++) begin
      steps = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
      mode  = int'($urandom_range(0, 5));
      if (mode > 2) mode = 0;
      g     = lw_entry(steps) - 4 + int'($urandom_range(0, 24));
      do_req(2'($urandom), 1'($urandom), steps, mode, g);
    end

    do_req(2'd3, 1'b0, 255, 0, 0);
    reset_mid_step();
    do_req(2'd2, 1'b0, 4, 0, 0);

    repeat (5) @(negedge clk_sys);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
